// File: rtl/pwm_audio_dac.sv
// pwm_audio_dac: 8-bit sample to 1-bit PWM audio converter.
// One PWM frame is 256 counter steps of PRESCALE clocks each. The sample and
// the mute request are captured only at end-of-frame, so a pulse is never
// reshaped once it has started.
// Optional feature macro: PWM_DAC_SOFT_MUTE_EN (adds the RAMP state and the
// RAMP_STEP parameter for a click-free fade into mute).
//
// Handshake note: there is no valid/ready pair here. The sample stream is
// treated as continuously valid and is consumed in the cycle of each
// end-of-frame (and on the enabling edge). frame_start marks the first cycle
// of every frame so an upstream source can align its updates.
module pwm_audio_dac #(
    parameter int PRESCALE = 1
`ifdef PWM_DAC_SOFT_MUTE_EN
    ,
    parameter int RAMP_STEP = 4
`endif
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       enable,
    input  logic       mute,
    input  logic [7:0] sample,
    output logic       pwm_out,
    output logic       frame_start,
    output logic       muted,
    output logic [1:0] dbg_state
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

`ifdef PWM_DAC_SOFT_MUTE_EN
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PLAY  = 2'd1,
        S_RAMP  = 2'd2,
        S_MUTED = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PLAY  = 2'd1,
        S_MUTED = 2'd3
    } state_t;
`endif

    state_t          r_state;
    logic [PW-1:0]   r_pre;
    logic [7:0]      r_cnt;
    logic [7:0]      r_duty;
    logic            r_frame_start;
    logic            r_muted;

    state_t          w_state_nxt;
    logic [PW-1:0]   w_pre_nxt;
    logic [7:0]      w_cnt_nxt;
    logic [7:0]      w_duty_nxt;
    logic            w_frame_start_nxt;
    logic            w_muted_nxt;
    logic            w_tick;
    logic            w_eof;

    assign w_tick = (r_pre == PW'(PRESCALE - 1));
    assign w_eof  = w_tick && (r_cnt == 8'd255);

`ifdef PWM_DAC_SOFT_MUTE_EN
    // Fade step is computed 9 bits wide so an underflow saturates at zero.
    logic [8:0] w_ramp_diff;
    logic [7:0] w_ramp_duty;
    assign w_ramp_diff = {1'b0, r_duty} - 9'(RAMP_STEP);
    assign w_ramp_duty = w_ramp_diff[8] ? 8'd0 : w_ramp_diff[7:0];
`endif

    // Next-state and datapath decode; defaults hold everything except frame_start.
    always_comb begin
        w_state_nxt       = r_state;
        w_pre_nxt         = r_pre;
        w_cnt_nxt         = r_cnt;
        w_duty_nxt        = r_duty;
        w_frame_start_nxt = 1'b0;

        if (r_state == S_IDLE) begin
            w_pre_nxt  = '0;
            w_cnt_nxt  = 8'd0;
            w_duty_nxt = 8'd0;
            if (enable) begin
                w_state_nxt       = S_PLAY;
                w_duty_nxt        = sample;
                w_frame_start_nxt = 1'b1;
            end
        end else if (!enable) begin
            // Abort from any running state: clear back to the reset picture.
            w_state_nxt = S_IDLE;
            w_pre_nxt   = '0;
            w_cnt_nxt   = 8'd0;
            w_duty_nxt  = 8'd0;
        end else begin
            w_pre_nxt = w_tick ? '0 : (r_pre + PW'(1));
            if (w_tick) begin
                w_cnt_nxt = r_cnt + 8'd1;
            end
            if (w_eof) begin
                w_frame_start_nxt = 1'b1;
                case (r_state)
                    S_PLAY: begin
                        if (!mute) begin
                            w_duty_nxt = sample;
                        end else begin
`ifdef PWM_DAC_SOFT_MUTE_EN
                            w_duty_nxt  = w_ramp_duty;
                            w_state_nxt = (w_ramp_duty == 8'd0) ? S_MUTED : S_RAMP;
`else
                            w_duty_nxt  = 8'd0;
                            w_state_nxt = S_MUTED;
`endif
                        end
                    end
`ifdef PWM_DAC_SOFT_MUTE_EN
                    S_RAMP: begin
                        if (!mute) begin
                            w_duty_nxt  = sample;
                            w_state_nxt = S_PLAY;
                        end else begin
                            w_duty_nxt = w_ramp_duty;
                            if (w_ramp_duty == 8'd0) begin
                                w_state_nxt = S_MUTED;
                            end
                        end
                    end
`endif
                    S_MUTED: begin
                        if (!mute) begin
                            w_duty_nxt  = sample;
                            w_state_nxt = S_PLAY;
                        end else begin
                            w_duty_nxt = 8'd0;
                        end
                    end
                    default: begin
                        w_state_nxt = S_IDLE;
                    end
                endcase
            end
        end

        w_muted_nxt = (w_state_nxt == S_MUTED);
    end

    // State and datapath registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_state       <= S_IDLE;
            r_pre         <= '0;
            r_cnt         <= 8'd0;
            r_duty        <= 8'd0;
            r_frame_start <= 1'b0;
            r_muted       <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pre         <= w_pre_nxt;
            r_cnt         <= w_cnt_nxt;
            r_duty        <= w_duty_nxt;
            r_frame_start <= w_frame_start_nxt;
            r_muted       <= w_muted_nxt;
        end
    end

    // Outputs decode registers only; no input reaches an output combinationally.
    assign pwm_out     = (r_state != S_IDLE) && (r_cnt < r_duty);
    assign frame_start = r_frame_start;
    assign muted       = r_muted;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_pwm_audio_dac.sv
// Bench for pwm_audio_dac: a PRESCALE=1 and a PRESCALE=3 instance share
// sample/mute/reset and have separate enables. A frame-level model predicts
// each frame's duty and muted flag from the values seen at end-of-frame.
module tb_pwm_audio_dac;

    localparam int M_PLAY  = 0;
    localparam int M_RAMP  = 1;
    localparam int M_MUTED = 2;
`ifdef PWM_DAC_SOFT_MUTE_EN
    localparam int STEP = 4;
`endif

    logic       clk;
    logic       nRst;
    logic       en1;
    logic       en3;
    logic       mute;
    logic [7:0] sample;
    logic       pwm1, fs1, mu1;
    logic       pwm3, fs3, mu3;
    logic [1:0] st1, st3;

    int n_checks;
    int n_pass;
    int exp_duty;
    int exp_mode;

    pwm_audio_dac #(.PRESCALE(1)) u_dut1 (
        .clk(clk), .nRst(nRst), .enable(en1), .mute(mute), .sample(sample),
        .pwm_out(pwm1), .frame_start(fs1), .muted(mu1), .dbg_state(st1)
    );

    pwm_audio_dac #(.PRESCALE(3)) u_dut3 (
        .clk(clk), .nRst(nRst), .enable(en3), .mute(mute), .sample(sample),
        .pwm_out(pwm3), .frame_start(fs3), .muted(mu3), .dbg_state(st3)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    // Reference model: decision taken at end-of-frame using current mute/sample.
    task automatic model_eof();
        int d;
        if (!mute) begin
            exp_duty = sample;
            exp_mode = M_PLAY;
        end else if (exp_mode == M_MUTED) begin
            exp_duty = 0;
        end else begin
`ifdef PWM_DAC_SOFT_MUTE_EN
            d = exp_duty - STEP;
            if (d < 0) d = 0;
            exp_duty = d;
            exp_mode = (d == 0) ? M_MUTED : M_RAMP;
`else
            d = 0;
            exp_duty = d;
            exp_mode = M_MUTED;
`endif
        end
    endtask

    task automatic start(input bit use3);
        @(negedge clk);
        if (use3) en3 = 1'b1;
        else en1 = 1'b1;
        exp_duty = sample;
        exp_mode = M_PLAY;
    endtask

    task automatic stop_all();
        @(negedge clk);
        en1 = 1'b0;
        en3 = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Observe one whole frame; optionally change sample/mute at index chg_at.
    task automatic run_frame(input bit use3, input int chg_at, input int new_sample,
                             input bit new_mute, input string tag);
        int p, len, hi, fs_bad, shape_bad, mu_bad, ed;
        logic pw, fs, mu;
        p = use3 ? 3 : 1;
        len = 256 * p;
        ed = exp_duty;
        hi = 0; fs_bad = 0; shape_bad = 0; mu_bad = 0;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            pw = use3 ? pwm3 : pwm1;
            fs = use3 ? fs3 : fs1;
            mu = use3 ? mu3 : mu1;
            if (pw === 1'b1) hi++;
            if (pw !== ((i / p) < ed)) shape_bad++;
            if (fs !== (i == 0)) fs_bad++;
            if (mu !== (exp_mode == M_MUTED)) mu_bad++;
            if (i == chg_at) begin
                sample = new_sample[7:0];
                mute = new_mute;
            end
        end
        n_checks++;
        if (hi !== ed * p) $display("FAIL %s high_count: got %0d expected %0d", tag, hi, ed * p);
        else n_pass++;
        n_checks++;
        if (shape_bad !== 0) $display("FAIL %s pwm_shape: got %0d bad cycles expected 0", tag, shape_bad);
        else n_pass++;
        n_checks++;
        if (fs_bad !== 0) $display("FAIL %s frame_start: got %0d bad cycles expected 0", tag, fs_bad);
        else n_pass++;
        n_checks++;
        if (mu_bad !== 0) $display("FAIL %s muted: got %0d bad cycles expected 0 (mode %0d)", tag, mu_bad, exp_mode);
        else n_pass++;
        model_eof();
    endtask

    task automatic test_reset();
        int bad;
        nRst = 1'b0; en1 = 1'b0; en3 = 1'b0; mute = 1'b0; sample = 8'd200;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({pwm1, fs1, mu1, pwm3, fs3, mu3} !== 6'b0)
            $display("FAIL reset_outputs: got %b expected 000000", {pwm1, fs1, mu1, pwm3, fs3, mu3});
        else n_pass++;
        nRst = 1'b1;
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if ({pwm1, fs1, mu1, pwm3, fs3, mu3} !== 6'b0) bad++;
        end
        n_checks++;
        if (bad !== 0) $display("FAIL idle_hold: got %0d nonzero cycles expected 0", bad);
        else n_pass++;
    endtask

    task automatic test_basic();
        sample = 8'd64; mute = 1'b0;
        start(1'b0);
        run_frame(1'b0, -1, 0, 1'b0, "basic64");
        // change at clk 10 of the frame: this frame stays 64, next is 200
        run_frame(1'b0, 10, 200, 1'b0, "midchange64");
        run_frame(1'b0, -1, 0, 1'b0, "after200");
        run_frame(1'b0, 0, 0, 1'b0, "duty200_to0");
        run_frame(1'b0, 100, 255, 1'b0, "duty0");
        run_frame(1'b0, -1, 0, 1'b0, "duty255");
        stop_all();
    endtask

    task automatic test_prescale3();
        sample = 8'd0; mute = 1'b0;
        start(1'b1);
        run_frame(1'b1, 300, 255, 1'b0, "p3_duty0");
        run_frame(1'b1, -1, 0, 1'b0, "p3_duty255");
        stop_all();
    endtask

    task automatic test_mute();
        mute = 1'b0;
`ifdef PWM_DAC_SOFT_MUTE_EN
        sample = 8'd10;
        start(1'b0);
        run_frame(1'b0, 40, 10, 1'b1, "soft_play10");
        run_frame(1'b0, -1, 0, 1'b0, "soft_ramp6");
        run_frame(1'b0, -1, 0, 1'b0, "soft_ramp2");
        run_frame(1'b0, 100, 77, 1'b0, "soft_muted0");
        run_frame(1'b0, -1, 0, 1'b0, "soft_unmute77");
`else
        sample = 8'd100;
        start(1'b0);
        run_frame(1'b0, 40, 100, 1'b1, "hard_play100");
        run_frame(1'b0, -1, 0, 1'b0, "hard_muted0");
        run_frame(1'b0, 100, 77, 1'b0, "hard_muted_again");
        run_frame(1'b0, -1, 0, 1'b0, "hard_unmute77");
`endif
        stop_all();
    endtask

    task automatic test_abort();
        mute = 1'b0; sample = 8'd200;
        start(1'b0);
        repeat (50) @(negedge clk);
        n_checks++;
        if (pwm1 !== 1'b1) $display("FAIL abort_pre_high: got %b expected 1", pwm1);
        else n_pass++;
        en1 = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({pwm1, fs1, mu1} !== 3'b000) $display("FAIL abort_play: got %b expected 000", {pwm1, fs1, mu1});
        else n_pass++;
        repeat (3) @(negedge clk);
        // enter MUTED, then abort inside the muted frame
        sample = 8'd4; mute = 1'b1;
        start(1'b0);
        run_frame(1'b0, -1, 0, 1'b1, "abort_play4");
        repeat (30) @(negedge clk);
        n_checks++;
        if (mu1 !== 1'b1) $display("FAIL abort_pre_muted: got %b expected 1", mu1);
        else n_pass++;
        en1 = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({pwm1, fs1, mu1} !== 3'b000) $display("FAIL abort_muted: got %b expected 000", {pwm1, fs1, mu1});
        else n_pass++;
        mute = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_random();
        string tag;
        sample = 8'($urandom_range(0, 255)); mute = 1'b0;
        start(1'b0);
        for (int f = 0; f < 10; f++) begin
            tag = $sformatf("rand%0d", f);
            run_frame(1'b0, $urandom_range(0, 255), $urandom_range(0, 255),
                      ($urandom_range(0, 2) == 0), tag);
        end
        stop_all();
    endtask

    initial begin
        n_checks = 0;
        n_pass = 0;
        exp_duty = 0;
        exp_mode = M_PLAY;
        test_reset();
        test_basic();
        test_prescale3();
        test_mute();
        test_abort();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
